// File: rtl/fuzzy_pkg.sv
// Shared types for the fuzzy datapath: rule strength, crisp value and defuzzifier states.
package fuzzy_pkg;

  typedef logic [15:0]       mu_t;
  typedef logic signed [7:0] crisp_t;

  localparam mu_t MU_ONE = 16'h7FFF;

  typedef enum logic [1:0] {
    ACC,
    DIV,
    OUT
  } defuzz_state_e;

endpackage

// File: rtl/seq_udiv.sv
// Unsigned restoring divider: one quotient bit per cycle, NW iterations after start.
module seq_udiv #(
  parameter int NW = 28,
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder
);

  localparam int CW = $clog2(NW + 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] quo_q, quo_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] dsr_q, dsr_d;
  logic [DW:0]   trial;

  // Dividend bits shift out of quo_q into the partial remainder, quotient bits shift in behind.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    dsr_d  = dsr_q;
    trial  = {rem_q, quo_q[NW-1]};
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(NW);
      quo_d  = dividend;
      rem_d  = '0;
      dsr_d  = divisor;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CW'(1);
        if (trial >= {1'b0, dsr_q}) begin
          rem_d = DW'(trial - {1'b0, dsr_q});
          quo_d = {quo_q[NW-2:0], 1'b1};
        end else begin
          rem_d = trial[DW-1:0];
          quo_d = {quo_q[NW-2:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dsr_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dsr_q  <= dsr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = busy_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/defuzz_wavg.sv
// Weighted-average defuzzifier: accumulates sum(mu*z) and sum(mu) per frame, then divides.
module defuzz_wavg #(
  parameter int MAX_RULES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_mu,
  input  logic signed [7:0] in_z,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic signed [7:0] out_y,
  output logic              out_zero,
  output logic              out_ovf
);
  import fuzzy_pkg::*;

  localparam int NUM_W = 24 + $clog2(MAX_RULES);
  localparam int DEN_W = 15 + $clog2(MAX_RULES);
  localparam int CNT_W = $clog2(MAX_RULES) + 1;

  defuzz_state_e            state_q, state_d;
  logic signed [NUM_W-1:0]  num_q, num_d, num_acc;
  logic [DEN_W-1:0]         den_q, den_d, den_acc;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  crisp_t                   out_y_q, out_y_d;
  logic                     out_zero_q, out_zero_d;
  logic                     out_ovf_q, out_ovf_d;

  mu_t                      mu_c;
  logic signed [23:0]       prod;
  logic                     accept, in_range, div_start, div_done;
  logic [NUM_W-1:0]         num_abs, div_quo;

  // The true average always lies inside the z range; the clamp only guards corrupted inputs.
  function automatic crisp_t sat_apply(input logic [NUM_W-1:0] q, input logic neg);
    if (neg) begin
      if (q > NUM_W'(128)) return crisp_t'(8'h80);
      return crisp_t'(8'd0 - q[7:0]);
    end
    if (q > NUM_W'(127)) return crisp_t'(8'h7F);
    return crisp_t'(q[7:0]);
  endfunction

  always_comb begin
    mu_c      = (in_mu > MU_ONE) ? MU_ONE : in_mu;
    prod      = 24'($signed(mu_c)) * 24'(in_z);
    accept    = in_valid && in_ready_q;
    in_range  = cnt_q < CNT_W'(MAX_RULES);
    num_acc   = in_range ? num_q + NUM_W'(prod) : num_q;
    den_acc   = in_range ? den_q + DEN_W'(mu_c) : den_q;
    num_abs   = num_acc[NUM_W-1] ? NUM_W'(-num_acc) : NUM_W'(num_acc);
    div_start = (state_q == ACC) && accept && in_last && (den_acc != '0);
  end

  // Divider is launched from the last beat's totals so DIV lasts exactly the iteration count.
  seq_udiv #(
    .NW(NUM_W),
    .DW(DEN_W)
  ) u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (num_abs),
    .divisor  (den_acc),
    .busy     (),
    .done     (div_done),
    .quotient (div_quo),
    .remainder()
  );

  always_comb begin
    state_d     = state_q;
    num_d       = num_q;
    den_d       = den_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_y_d     = out_y_q;
    out_zero_d  = out_zero_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ACC: begin
        if (accept) begin
          num_d = num_acc;
          den_d = den_acc;
          if (!in_range) ovf_d = 1'b1;
          if (cnt_q != CNT_W'(MAX_RULES)) cnt_d = cnt_q + CNT_W'(1);
          if (in_last) state_d = (den_acc == '0) ? OUT : DIV;
        end
      end
      DIV: begin
        if (div_done) begin
          out_y_d     = sat_apply(div_quo, num_q[NUM_W-1]);
          out_zero_d  = 1'b0;
          out_ovf_d   = ovf_q;
          out_valid_d = 1'b1;
          state_d     = OUT;
        end
      end
      OUT: begin
        // Entering OUT with out_valid low only happens on the zero-weight path.
        if (!out_valid_q) begin
          out_y_d     = '0;
          out_zero_d  = 1'b1;
          out_ovf_d   = ovf_q;
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          num_d       = '0;
          den_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    in_ready_d = (state_d == ACC);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACC;
      num_q       <= '0;
      den_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_zero_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_q       <= num_d;
      den_q       <= den_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_zero_q  <= out_zero_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_zero  = out_zero_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_defuzz_wavg.sv
// Directed bench for defuzz_wavg: hand-computed weighted averages, latency, backpressure, reset.
module tb_defuzz_wavg;

  localparam int NUM_W = 24 + $clog2(16);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [15:0]       in_mu = '0;
  logic signed [7:0] in_z = '0;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic signed [7:0] out_y;
  logic              out_zero;
  logic              out_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_last  = 0;

  defuzz_wavg #(.MAX_RULES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mu    (in_mu),
    .in_z     (in_z),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_zero (out_zero),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  // Present one beat and hold it until the DUT takes it; t_last records the accepting edge.
  task automatic send_beat(input logic [15:0] mu, input logic signed [7:0] z, input logic last);
    int  n  = 0;
    logic ok = 1'b0;
    in_valid = 1'b1;
    in_mu    = mu;
    in_z     = z;
    in_last  = last;
    while (!ok && n < 100) begin
      ok = in_ready;
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!ok) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL beat_accept: in_ready never high within 100 cycles");
    end else begin
      t_last = cyc;
    end
  endtask

  task automatic wait_result(output int lat);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    lat = cyc - t_last;
    if (!out_valid) begin
      n_tests++; n_fail++;
      $display("[TB] FAIL result_wait: out_valid never high within 200 cycles");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, in_ready, out_zero, out_ovf} !== 4'b0000 || out_y !== 8'sd0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: got valid=%b ready=%b y=%0d zero=%b ovf=%b, expected all 0",
               out_valid, in_ready, out_y, out_zero, out_ovf);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL ready_after_reset: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    send_beat(16'h7FFF, 8'sd40, 1'b0);
    send_beat(16'h7FFF, -8'sd20, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== 8'sd10 || out_zero !== 1'b0 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_avg: got y=%0d zero=%b ovf=%b expected y=10 zero=0 ovf=0",
               out_y, out_zero, out_ovf);
    end
    n_tests++;
    if (lat !== NUM_W + 1) begin
      n_fail++;
      $display("[TB] FAIL div_latency: got %0d expected %0d", lat, NUM_W + 1);
    end
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL handshake_release: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_trunc();
    int lat;
    send_beat(16'h4000, 8'sd100, 1'b0);
    send_beat(16'h2000, -8'sd50, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== 8'sd50) begin
      n_fail++;
      $display("[TB] FAIL weighted_avg: got %0d expected 50", out_y);
    end
    @(posedge clk); #1;
    send_beat(16'h7FFF, -8'sd3, 1'b0);
    send_beat(16'h7FFF, 8'sd0, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== -8'sd1) begin
      n_fail++;
      $display("[TB] FAIL neg_trunc: got %0d expected -1", out_y);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat;
    send_beat(16'h0000, 8'sd55, 1'b0);
    send_beat(16'h0000, -8'sd7, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== 8'sd0 || out_zero !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL zero_frame: got y=%0d zero=%b expected y=0 zero=1", out_y, out_zero);
    end
    n_tests++;
    if (lat !== 1) begin
      n_fail++;
      $display("[TB] FAIL zero_latency: got %0d expected 1", lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   lat;
    int   h;
    logic stable = 1'b1;
    out_ready = 1'b0;
    send_beat(16'h7FFF, 8'sd40, 1'b0);
    send_beat(16'h7FFF, -8'sd20, 1'b1);
    wait_result(lat);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_y !== 8'sd10 || in_ready !== 1'b0) stable = 1'b0;
    end
    n_tests++;
    if (!stable) begin
      n_fail++;
      $display("[TB] FAIL hold_stable: got valid=%b y=%0d ready=%b expected 1/10/0",
               out_valid, out_y, in_ready);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mu     = 16'h4000;
    in_z      = 8'sd100;
    @(posedge clk); #1;
    h = cyc;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL post_handshake: got valid=%b ready=%b expected 0/1", out_valid, in_ready);
    end
    send_beat(16'h4000, 8'sd100, 1'b0);
    n_tests++;
    if (t_last !== h + 1) begin
      n_fail++;
      $display("[TB] FAIL next_accept: got edge %0d expected %0d", t_last, h + 1);
    end
    send_beat(16'h2000, -8'sd50, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== 8'sd50) begin
      n_fail++;
      $display("[TB] FAIL second_frame: got %0d expected 50", out_y);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ovf_clamp();
    int lat;
    for (int i = 0; i < 16; i++) send_beat(16'h7FFF, 8'sd10, 1'b0);
    send_beat(16'h7FFF, 8'sd90, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== 8'sd10 || out_ovf !== 1'b1 || out_zero !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL overflow: got y=%0d ovf=%b zero=%b expected y=10 ovf=1 zero=0",
               out_y, out_ovf, out_zero);
    end
    @(posedge clk); #1;
    send_beat(16'hFFFF, 8'sd100, 1'b0);
    send_beat(16'h4000, 8'sd0, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== 8'sd66 || out_ovf !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mu_clamp: got y=%0d ovf=%b expected y=66 ovf=0", out_y, out_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    int   lat;
    logic quiet = 1'b1;
    send_beat(16'h7FFF, 8'sd100, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_frame: got valid=%b ready=%b expected 0/0", out_valid, in_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_beat(16'h7FFF, 8'sd40, 1'b0);
    send_beat(16'h7FFF, -8'sd20, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== 8'sd10) begin
      n_fail++;
      $display("[TB] FAIL after_frame_reset: got %0d expected 10", out_y);
    end
    @(posedge clk); #1;
    send_beat(16'h4000, 8'sd100, 1'b0);
    send_beat(16'h2000, -8'sd50, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < NUM_W + 10; i++) begin
      if (out_valid !== 1'b0) quiet = 1'b0;
      @(posedge clk); #1;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_div: got out_valid=1 after abort expected 0");
    end
    send_beat(16'h7FFF, -8'sd3, 1'b0);
    send_beat(16'h7FFF, 8'sd0, 1'b1);
    wait_result(lat);
    n_tests++;
    if (out_y !== -8'sd1 || out_zero !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL after_div_reset: got y=%0d zero=%b expected y=-1 zero=0", out_y, out_zero);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_trunc();
    test_zero();
    test_back_to_back();
    test_ovf_clamp();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
